// File: rtl/col_parity_theta_engine.sv
// col_parity_theta_engine
// Applies the Keccak theta step to a 64-slice x 25-bit state held by an
// external column-parity file reader. It runs two sweeps over the slices:
// first it gathers the 5 column parities of every slice, then it streams out
// theta-mixed slices.
//
// Ports
//   clk           : rising-edge clock
//   rst           : asynchronous active-low reset
//   start         : run request, only honoured in IDLE
//   file_index_in : file number, captured when start is accepted
//   read_file     : one-cycle load pulse to the reader (LOAD state)
//   file_index    : captured file number, held until the next accepted start
//   line_index    : slice address to the reader
//   data_in       : reader slice mem[line_index], combinational
//   data_out      : theta-mixed slice (registered)
//   out_index     : slice number z of data_out
//   out_valid     : data_out / out_index valid
//   busy          : high whenever the engine is not IDLE
//   done          : one-cycle pulse together with the last output slice
module col_parity_theta_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  file_index_in,
  output logic        read_file,
  output logic [9:0]  file_index,
  output logic [5:0]  line_index,
  input  logic [24:0] data_in,
  output logic [24:0] data_out,
  output logic [5:0]  out_index,
  output logic        out_valid,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PASS1 = 3'd2,
    ST_PASS2 = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Column parity of one slice: bit x is the XOR of lane (x, y) over all y.
  function automatic logic [4:0] col_parity(input logic [24:0] slice);
    logic [4:0] par;
    par = 5'd0;
    for (int y = 0; y < 5; y++) begin
      par = par ^ slice[5*y +: 5];
    end
    return par;
  endfunction

  // Theta mixing of one slice given the parities of slice z and slice z-1.
  function automatic logic [24:0] theta_mix(input logic [24:0] slice,
                                            input logic [4:0]  par_cur,
                                            input logic [4:0]  par_prev);
    logic [24:0] res;
    res = slice;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        res[5*y+x] = slice[5*y+x] ^ par_cur[(x+4)%5] ^ par_prev[(x+1)%5];
      end
    end
    return res;
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic [4:0]  par_r [64];
  logic [5:0]  line_r;
  logic [5:0]  line_nxt_s;
  logic [5:0]  line_prev_s;
  logic [9:0]  fidx_r;
  logic [9:0]  fidx_nxt_s;
  logic        read_file_r;
  logic        read_file_nxt_s;
  logic        busy_r;
  logic        busy_nxt_s;
  logic        out_valid_r;
  logic        out_valid_nxt_s;
  logic        done_r;
  logic        done_nxt_s;
  logic [24:0] data_out_r;
  logic [24:0] data_out_nxt_s;
  logic [5:0]  out_index_r;
  logic [5:0]  out_index_nxt_s;
  logic        last_slice_s;

  // Slice 0 mixes with slice 63: the 6-bit subtraction wraps on its own.
  assign line_prev_s  = line_r - 6'd1;
  assign last_slice_s = (line_r == 6'd63);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_LOAD;
        else       state_nxt_s = ST_IDLE;
      end
      ST_LOAD:  state_nxt_s = ST_PASS1;
      ST_PASS1: begin
        if (last_slice_s) state_nxt_s = ST_PASS2;
        else              state_nxt_s = ST_PASS1;
      end
      ST_PASS2: begin
        if (last_slice_s) state_nxt_s = ST_DONE;
        else              state_nxt_s = ST_PASS2;
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Output logic: next values of every registered output, so that each
  // output changes on the same edge that enters the state it belongs to.
  always_comb begin
    read_file_nxt_s = (state_nxt_s == ST_LOAD);
    busy_nxt_s      = (state_nxt_s != ST_IDLE);
    out_valid_nxt_s = (state_r == ST_PASS2);
    done_nxt_s      = (state_r == ST_PASS2) && last_slice_s;
    if ((state_r == ST_IDLE) && start) begin
      fidx_nxt_s = file_index_in;
    end else begin
      fidx_nxt_s = fidx_r;
    end
    if ((state_r == ST_PASS1) || (state_r == ST_PASS2)) begin
      line_nxt_s = line_r + 6'd1;
    end else begin
      line_nxt_s = 6'd0;
    end
    if (state_r == ST_PASS2) begin
      data_out_nxt_s  = theta_mix(data_in, par_r[line_r], par_r[line_prev_s]);
      out_index_nxt_s = line_r;
    end else begin
      data_out_nxt_s  = data_out_r;
      out_index_nxt_s = out_index_r;
    end
  end

  // Registered outputs and slice address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_file_r <= 1'b0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
      fidx_r      <= 10'd0;
      line_r      <= 6'd0;
      data_out_r  <= 25'd0;
      out_index_r <= 6'd0;
    end else begin
      read_file_r <= read_file_nxt_s;
      busy_r      <= busy_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      done_r      <= done_nxt_s;
      fidx_r      <= fidx_nxt_s;
      line_r      <= line_nxt_s;
      data_out_r  <= data_out_nxt_s;
      out_index_r <= out_index_nxt_s;
    end
  end

  // Column parity store, written one slice per cycle during the first sweep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) begin
        par_r[i] <= 5'd0;
      end
    end else begin
      if (state_r == ST_PASS1) begin
        par_r[line_r] <= col_parity(data_in);
      end else begin
        par_r[line_r] <= par_r[line_r];
      end
    end
  end

  assign read_file  = read_file_r;
  assign file_index = fidx_r;
  assign line_index = line_r;
  assign data_out   = data_out_r;
  assign out_index  = out_index_r;
  assign out_valid  = out_valid_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_col_parity_theta_engine.sv
// Testbench for col_parity_theta_engine: models the file reader, checks every
// cycle of each run against a lane-level theta model, plus a table of
// directed files and hand-written protocol/reset sequences.
module tb_col_parity_theta_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  file_index_in;
  logic        read_file;
  logic [9:0]  file_index;
  logic [5:0]  line_index;
  logic [24:0] data_in;
  logic [24:0] data_out;
  logic [5:0]  out_index;
  logic        out_valid;
  logic        busy;
  logic        done;

  col_parity_theta_engine dut (
    .clk(clk), .rst(rst), .start(start), .file_index_in(file_index_in),
    .read_file(read_file), .file_index(file_index), .line_index(line_index),
    .data_in(data_in), .data_out(data_out), .out_index(out_index),
    .out_valid(out_valid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reader model: the staged file is copied into memory on the LOAD edge.
  logic [24:0] file_s [64];
  logic [24:0] mem    [64];
  assign data_in = mem[line_index];
  always @(posedge clk) begin
    if (read_file) begin
      for (int i = 0; i < 64; i++) mem[i] <= file_s[i];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [24:0] exp_q [64];
  logic [24:0] got_q [64];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] fold5(input logic [24:0] s);
    return s[4:0] ^ s[9:5] ^ s[14:10] ^ s[19:15] ^ s[24:20];
  endfunction

  // Theta over the whole file: D = rotl(C[z]) ^ rotr(C[z-1]), spread to all rows.
  task automatic build_model();
    logic [4:0] c [64];
    logic [4:0] d;
    for (int z = 0; z < 64; z++) c[z] = fold5(file_s[z]);
    for (int z = 0; z < 64; z++) begin
      d = {c[z][3:0], c[z][4]} ^ {c[(z+63)%64][0], c[(z+63)%64][4:1]};
      exp_q[z] = file_s[z] ^ {5{d}};
    end
  endtask

  // One run, cycle 1 = LOAD. s1/s2: cycles with a spurious start pulse.
  // chain: raise start in cycle 131 with nfidx. prestarted: start already
  // accepted by the previous run. abort_c: cycle where reset is pulled (0 = none).
  task automatic run(input logic [9:0] fidx, input int s1, input int s2,
                     input bit chain, input logic [9:0] nfidx,
                     input bit prestarted, input int abort_c, input string tag);
    logic [50:0] act, exp;
    logic e_v, li_chk;
    logic [5:0] e_li;
    if (!prestarted) begin
      start = 1'b1;
      file_index_in = fidx;
    end
    build_model();
    for (int c = 1; c <= 131; c++) begin
      @(posedge clk); #1;
      if (c == abort_c) begin
        rst = 1'b0; start = 1'b0;
        #1;
        check($sformatf("%s_abort_zero", tag),
              {read_file, busy, out_valid, done, file_index, line_index, out_index, data_out}, 51'd0);
        for (int k = 0; k < 4; k++) begin
          @(posedge clk); #1;
          check($sformatf("%s_abort_hold%0d", tag, k), {read_file, busy, out_valid, done}, 4'd0);
        end
        rst = 1'b1;
        return;
      end
      e_v    = (c >= 67) && (c <= 130);
      li_chk = (c >= 2) && (c <= 129);
      e_li   = (c <= 65) ? 6'(c - 2) : 6'(c - 66);
      exp = {(c == 1), (c <= 130), e_v, (c == 130), fidx,
             li_chk ? e_li : 6'd0,
             e_v ? 6'(c - 67) : 6'd0,
             e_v ? exp_q[(c - 67) % 64] : 25'd0};
      act = {read_file, busy, out_valid, done, file_index,
             li_chk ? line_index : 6'd0,
             e_v ? out_index : 6'd0,
             e_v ? data_out : 25'd0};
      check($sformatf("%s_cycle%0d", tag, c), act, exp);
      if (e_v) got_q[c - 67] = data_out;
      if (chain && (c == 131)) begin
        start = 1'b1;
        file_index_in = nfidx;
      end else begin
        start = (c == s1) || (c == s2);
        file_index_in = 10'($urandom);
      end
    end
  endtask

  typedef struct {
    logic [24:0] bg;
    int          hot_z;
    logic [24:0] hot_val;
    logic [9:0]  fidx;
    int          z_a;
    logic [24:0] exp_a;
    int          z_b;
    logic [24:0] exp_b;
    logic [24:0] exp_rest;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int bad;
    vecs[0] = '{25'h0000000, 0,  25'h0000000, 10'd3,   0,  25'h0000000, 1, 25'h0000000, 25'h0000000};
    vecs[1] = '{25'h1FFFFFF, 0,  25'h1FFFFFF, 10'd17,  0,  25'h1FFFFFF, 1, 25'h1FFFFFF, 25'h1FFFFFF};
    vecs[2] = '{25'h0000000, 0,  25'h0000001, 10'd512, 0,  25'h0210843, 1, 25'h1084210, 25'h0000000};
    vecs[3] = '{25'h0000000, 63, 25'h0000001, 10'd1023, 63, 25'h0210843, 0, 25'h1084210, 25'h0000000};

    rst = 1'b0; start = 1'b0; file_index_in = 10'h2AA;
    for (int i = 0; i < 64; i++) begin file_s[i] = 25'd0; mem[i] = 25'd0; end
    repeat (3) @(posedge clk);
    #1;
    check("reset_state",
          {read_file, busy, out_valid, done, file_index, line_index, out_index, data_out}, 51'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", {read_file, busy, out_valid, done, file_index}, 14'd0);

    // Directed files from the table.
    for (int v = 0; v < 4; v++) begin
      for (int z = 0; z < 64; z++) file_s[z] = vecs[v].bg;
      file_s[vecs[v].hot_z] = vecs[v].hot_val;
      run(vecs[v].fidx, 0, 0, 1'b0, 10'd0, 1'b0, 0, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_za", v), {39'd0, got_q[vecs[v].z_a]}, {39'd0, vecs[v].exp_a});
      check($sformatf("vec%0d_zb", v), {39'd0, got_q[vecs[v].z_b]}, {39'd0, vecs[v].exp_b});
      bad = 0;
      for (int z = 0; z < 64; z++) begin
        if (z != vecs[v].z_a && z != vecs[v].z_b && got_q[z] !== vecs[v].exp_rest) bad++;
      end
      check($sformatf("vec%0d_rest_bad_slices", v), 64'(bad), 64'd0);
    end

    // Protocol: spurious starts in cycles 40 and 130, then start in 131.
    for (int z = 0; z < 64; z++) file_s[z] = 25'($urandom);
    run(10'd77, 40, 130, 1'b1, 10'd200, 1'b0, 0, "proto");
    for (int z = 0; z < 64; z++) file_s[z] = 25'($urandom);
    run(10'd200, 0, 0, 1'b0, 10'd0, 1'b1, 0, "chained");

    // Reset in the middle of the second sweep, then a clean run.
    for (int z = 0; z < 64; z++) file_s[z] = 25'($urandom);
    run(10'd5, 0, 0, 1'b0, 10'd0, 1'b0, 90, "abort");
    for (int z = 0; z < 64; z++) file_s[z] = 25'($urandom);
    run(10'd6, 0, 0, 1'b0, 10'd0, 1'b0, 0, "after_abort");

    // Random files.
    for (int r = 0; r < 4; r++) begin
      for (int z = 0; z < 64; z++) file_s[z] = 25'($urandom);
      run(10'($urandom), 0, 0, 1'b0, 10'd0, 1'b0, 0, $sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
